// File: rtl/occupancy_controller.sv
// Room occupancy counter with full/empty locks, near-full warning and sticky error flags.
// Define OCC_LIGHT_HOLD_EN to keep the light on for HOLD_CYCLES after the room empties.
module occupancy_controller #(
  parameter int unsigned CAPACITY    = 4,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned WARN_LEVEL  = 3,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             entered,
  input  logic             exited,
  output logic [CNT_W-1:0] count,
  output logic             entryLock,
  output logic             exitLock,
  output logic             lightOn,
  output logic             nearFull,
  output logic             ovfErr,
  output logic             unfErr
);

  localparam logic [CNT_W-1:0] CapVal  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] WarnVal = CNT_W'(WARN_LEVEL);
  localparam logic [CNT_W-1:0] OneVal  = CNT_W'(1);

  localparam bit ParamsOk = (CAPACITY >= 1) && (CAPACITY <= 255) &&
                            ((1 << CNT_W) > CAPACITY) &&
                            (WARN_LEVEL >= 1) && (WARN_LEVEL <= CAPACITY) &&
                            (HOLD_CYCLES >= 1) && (HOLD_CYCLES <= 255);

  if (!ParamsOk) begin : g_illegal_params
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             inc_req, dec_req;
  logic             is_full, is_empty;

  assign inc_req  = entered & ~exited;
  assign dec_req  = exited & ~entered;
  assign is_full  = (count_q == CapVal);
  assign is_empty = (count_q == '0);

  // Simultaneous entry and exit cancel out and never raise an error.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (inc_req) begin
      if (is_full) ovf_d = 1'b1;
      else         count_d = count_q + OneVal;
    end else if (dec_req) begin
      if (is_empty) unf_d = 1'b1;
      else          count_d = count_q - OneVal;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count     = count_q;
  assign entryLock = is_full;
  assign exitLock  = is_empty;
  assign nearFull  = (count_q >= WarnVal);
  assign ovfErr    = ovf_q;
  assign unfErr    = unf_q;

`ifdef OCC_LIGHT_HOLD_EN
  logic [7:0] timer_q, timer_d;

  // Timer starts when the last person leaves; a new entry cancels it.
  always_comb begin
    timer_d = timer_q;
    if (inc_req) begin
      timer_d = '0;
    end else if (dec_req && (count_q == OneVal)) begin
      timer_d = 8'(HOLD_CYCLES);
    end else if (timer_q != '0) begin
      timer_d = timer_q - 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  assign lightOn = ~is_empty | (timer_q != '0);
`else
  assign lightOn = ~is_empty;
`endif

endmodule

// File: tb/tb_occupancy_controller.sv
// Scoreboard bench for occupancy_controller: directed scenarios plus random traffic
// against an arithmetic reference model; follows OCC_LIGHT_HOLD_EN when defined.
module tb_occupancy_controller;

  localparam int CAP  = 4;
  localparam int CW   = 3;
  localparam int WARN = 3;
  localparam int HOLD = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          entered = 1'b0;
  logic          exited = 1'b0;
  logic [CW-1:0] count;
  logic          entryLock, exitLock, lightOn, nearFull, ovfErr, unfErr;

  occupancy_controller #(
    .CAPACITY   (CAP),
    .CNT_W      (CW),
    .WARN_LEVEL (WARN),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .entered  (entered),
    .exited   (exited),
    .count    (count),
    .entryLock(entryLock),
    .exitLock (exitLock),
    .lightOn  (lightOn),
    .nearFull (nearFull),
    .ovfErr   (ovfErr),
    .unfErr   (unfErr)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cnt;
    bit el;
    bit xl;
    bit nf;
    bit lo;
    bit ov;
    bit un;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  // Reference state: occupancy as a plain integer plus remaining light-hold cycles.
  int m_cnt = 0;
  bit m_ov = 0;
  bit m_un = 0;
  int m_hold = 0;

  task automatic model_step(input bit r, input bit en, input bit ex);
    int prev;
    exp_t e;
    prev = m_cnt;
    if (r) begin
      m_cnt = 0; m_ov = 0; m_un = 0; m_hold = 0;
    end else begin
      if (en && !ex) begin
        if (m_cnt < CAP) m_cnt++;
        else m_ov = 1;
      end else if (ex && !en) begin
        if (m_cnt > 0) m_cnt--;
        else m_un = 1;
      end
`ifdef OCC_LIGHT_HOLD_EN
      if (en && !ex) m_hold = 0;
      else if (prev == 1 && m_cnt == 0) m_hold = HOLD;
      else if (m_hold > 0) m_hold--;
`endif
    end
    e.cnt = m_cnt;
    e.el  = (m_cnt == CAP);
    e.xl  = (m_cnt == 0);
    e.nf  = (m_cnt >= WARN);
    e.lo  = (m_cnt != 0) || (m_hold > 0);
    e.ov  = m_ov;
    e.un  = m_un;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit en, input bit ex);
    @(negedge clock);
    reset   = r;
    entered = en;
    exited  = ex;
    model_step(r, en, ex);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, so compare just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count",     32'(count),     32'(e.cnt));
        chk("entryLock", 32'(entryLock), 32'(e.el));
        chk("exitLock",  32'(exitLock),  32'(e.xl));
        chk("nearFull",  32'(nearFull),  32'(e.nf));
        chk("lightOn",   32'(lightOn),   32'(e.lo));
        chk("ovfErr",    32'(ovfErr),    32'(e.ov));
        chk("unfErr",    32'(unfErr),    32'(e.un));
      end
    end
  end

  initial begin
    // Reset for two edges.
    cyc(1, 0, 0);
    cyc(1, 1, 1);
    // Fill and overflow.
    repeat (5) cyc(0, 1, 0);
    cyc(0, 1, 1);               // simultaneous at 4
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 1, 1);               // simultaneous at 2
    // Drain and underflow.
    repeat (3) cyc(0, 0, 1);
    cyc(0, 1, 1);               // simultaneous at 0
    cyc(0, 0, 0);
    // Clear sticky flags, then light hold run.
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    repeat (5) cyc(0, 0, 0);
    // Repeat with an entry on the second hold cycle.
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (4) cyc(0, 0, 0);
    // Reset from full with overflow set.
    repeat (5) cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    // Random traffic, occasional reset.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom));
    end
    cyc(0, 0, 0);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    wait (stim_done);
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/occupancy_controller.md
OCCUPANCY_CONTROLLER -- requirements
Module: occupancy_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CAPACITY, 4, maximum occupancy; legal range 1..255.
- CNT_W, 3, occupancy counter width; SHALL satisfy 2^CNT_W > CAPACITY.
- WARN_LEVEL, 3, occupancy at or above which nearFull asserts; legal range 1..CAPACITY.
- HOLD_CYCLES, 8, light hold time in cycles; legal range 1..255; used only when OCC_LIGHT_HOLD_EN is defined.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- entered  input  1  one person entered this cycle.
- exited  input  1  one person exited this cycle.
- count  output  CNT_W  current occupancy.
- entryLock  output  1  1 = room full, entry barred.
- exitLock  output  1  1 = room empty, exit barred.
- lightOn  output  1  room light enable.
- nearFull  output  1  count >= WARN_LEVEL.
- ovfErr  output  1  sticky flag: entry attempted while full.
- unfErr  output  1  sticky flag: exit attempted while empty.

Function
REQ-003 Occupancy state SHALL be a registered counter, count, with one of three states: EMPTY (count=0), PARTIAL (0<count<CAPACITY), FULL (count=CAPACITY).
REQ-004 An event sampled at rising edge k SHALL be reflected on count and all derived outputs immediately after edge k; latency is one cycle and there is no combinational input-to-output path.
REQ-005 entered=1, exited=0: count SHALL increment by 1 if count<CAPACITY; at FULL, count SHALL hold and ovfErr SHALL set.
REQ-006 entered=0, exited=1: count SHALL decrement by 1 if count>0; at EMPTY, count SHALL hold and unfErr SHALL set.
REQ-007 entered=1, exited=1: count SHALL hold in every state and no error flag SHALL set.
REQ-008 entered=0, exited=0: count SHALL hold.
REQ-009 count SHALL never wrap; it SHALL stay within 0..CAPACITY in all cases.
REQ-010 entryLock SHALL equal (count==CAPACITY); exitLock SHALL equal (count==0); nearFull SHALL equal (count>=WARN_LEVEL). All three are decoded from registered count only.
REQ-011 ovfErr and unfErr, once set, SHALL remain 1 until reset.
REQ-012 Without light hold (see REQ-016), lightOn SHALL equal (count!=0).

Reset
REQ-013 While reset=1 at a rising edge, the block SHALL load count=0, ovfErr=0, unfErr=0 and hold timer=0, ignoring entered and exited.
REQ-014 After reset: entryLock=0, exitLock=1, nearFull=0, lightOn=0.
REQ-015 Reset asserted mid-operation, including from FULL or during a light hold, SHALL take effect at the next edge with no residual state.

Configuration
REQ-016 The macro OCC_LIGHT_HOLD_EN SHALL control light hold.
- Defined: when count goes from 1 to 0, a hold timer SHALL load HOLD_CYCLES. lightOn SHALL stay 1 while the timer is nonzero, and the timer SHALL decrement once per cycle. An entry during the hold SHALL clear the timer; lightOn then follows count.
- Not defined: no timer logic SHALL be present, and lightOn SHALL follow REQ-012.
- Both builds SHALL be identical in every other respect.

Verification
Bench settings: CAPACITY=4, WARN_LEVEL=3, HOLD_CYCLES=3.
REQ-017 Reset: hold reset=1 for 2 edges -> count=0, exitLock=1, entryLock=0, lightOn=0, ovfErr=0, unfErr=0.
REQ-018 Fill and overflow: 5 consecutive entered-only cycles -> count goes 1,2,3,4,4; nearFull=1 from count=3; entryLock=1 at 4; ovfErr=1 after the fifth event.
REQ-019 Simultaneous events: at count=0, count=2 and count=4, apply entered=exited=1 -> count unchanged each time and no error flag set.
REQ-020 Drain and underflow: from count=2, 3 exited-only cycles -> count goes 1,0,0; exitLock=1 at 0; unfErr=1.
REQ-021 Light hold, macro defined: count 1->0 -> lightOn=1 for exactly 3 more cycles, then 0. A repeat run with an entered pulse on the second hold cycle -> lightOn stays 1 and count=1. With the macro undefined -> lightOn=0 in the cycle count reaches 0.
REQ-022 Mid-operation reset: assert reset at FULL with ovfErr=1 -> next edge gives count=0, ovfErr=0, lightOn=0.
